// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read, a single holding slot towards decode, redirect
// with late-beat drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic [6:0]  INSTRUCTION_FORMAT,
    output logic [31:0] FETCH_COUNT
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] fetch_count_q;
    logic        instr_valid_q;
    logic        drop_q;
    logic [31:0] redirect_target;

    assign redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;

    // Request is suppressed by a same-cycle redirect so a stale address never goes out.
    assign IMEM_REQ           = (state_q == StReq) & ~REDIRECT & ~RESET;
    assign IMEM_ADDR          = pc_q;
    assign INSTR_VALID        = instr_valid_q;
    assign INSTR              = instr_q;
    assign INSTR_PC           = instr_pc_q;
    assign INSTRUCTION_FORMAT = instr_q[6:0];
    assign FETCH_COUNT        = fetch_count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= 32'h0;
        end else if (REDIRECT) begin
            pc_q          <= redirect_target;
            instr_valid_q <= 1'b0;
            if (state_q == StWait && !IMEM_RVALID) begin
                // Read still in flight: stay and swallow its beat when it lands.
                drop_q  <= 1'b1;
                state_q <= StWait;
            end else begin
                drop_q  <= 1'b0;
                state_q <= StReq;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (IMEM_RVALID) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= StReq;
                        end else begin
                            instr_q       <= IMEM_RDATA;
                            instr_pc_q    <= pc_q;
                            pc_q          <= pc_q + 32'd4;
                            instr_valid_q <= 1'b1;
                            state_q       <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (instr_valid_q && INSTR_READY) begin
                        instr_valid_q <= 1'b0;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= StReq;
                    end
                end
                default: begin
                    state_q <= StReq;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus hand sequences for async reset, counter wrap
// and PC wrap.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  instr_fmt;
    logic [31:0] fetch_count;

    logic        rvalid_tb;
    logic [31:0] rdata_tb;
    logic        auto_mem;
    logic        pend;

    // Second instance exercising PC wrap, with its own 1-cycle memory.
    logic        reset2;
    logic        req2;
    logic [31:0] addr2;
    logic        pend2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic [6:0]  fmt2;
    logic [31:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) pend  <= imem_req;
    always @(posedge CLK) pend2 <= req2;

    assign imem_rvalid = auto_mem ? pend : rvalid_tb;
    assign imem_rdata  = auto_mem ? 32'h0000_0013 : rdata_tb;

    fetch_unit dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .IMEM_REQ           (imem_req),
        .IMEM_ADDR          (imem_addr),
        .IMEM_RVALID        (imem_rvalid),
        .IMEM_RDATA         (imem_rdata),
        .REDIRECT           (redirect),
        .REDIRECT_PC        (redirect_pc),
        .INSTR_VALID        (instr_valid),
        .INSTR_READY        (instr_ready),
        .INSTR              (instr),
        .INSTR_PC           (instr_pc),
        .INSTRUCTION_FORMAT (instr_fmt),
        .FETCH_COUNT        (fetch_count)
    );

    fetch_unit #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (32'h0000_0013)
    ) dut2 (
        .CLK                (CLK),
        .RESET              (reset2),
        .IMEM_REQ           (req2),
        .IMEM_ADDR          (addr2),
        .IMEM_RVALID        (pend2),
        .IMEM_RDATA         (32'h0000_0013),
        .REDIRECT           (1'b0),
        .REDIRECT_PC        (32'h0),
        .INSTR_VALID        (valid2),
        .INSTR_READY        (1'b1),
        .INSTR              (instr2),
        .INSTR_PC           (ipc2),
        .INSTRUCTION_FORMAT (fmt2),
        .FETCH_COUNT        (cnt2)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic redir, input logic [31:0] rpc, input logic rvalid,
                               input logic [31:0] rdata, input logic ready, input logic ereq,
                               input logic [31:0] eaddr, input logic evalid,
                               input logic [31:0] einstr, input logic [31:0] eipc,
                               input logic [31:0] ecnt);
        vec_t r;
        r.redir = redir; r.rpc = rpc; r.rvalid = rvalid; r.rdata = rdata; r.ready = ready;
        r.exp_req = ereq; r.exp_addr = eaddr; r.exp_valid = evalid; r.exp_instr = einstr;
        r.exp_ipc = eipc; r.exp_cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] einstr,
                           input logic [31:0] eipc, input logic [31:0] ecnt);
        chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, ereq});
        if (ereq) chk({tag, " imem_addr"}, imem_addr, eaddr);
        chk({tag, " instr_valid"}, {31'h0, instr_valid}, {31'h0, evalid});
        chk({tag, " instr"}, instr, einstr);
        chk({tag, " instr_pc"}, instr_pc, eipc);
        chk({tag, " format"}, {25'h0, instr_fmt}, {25'h0, einstr[6:0]});
        chk({tag, " fetch_count"}, fetch_count, ecnt);
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] N  = 32'h0000_0013;
    localparam logic [31:0] I1 = 32'h0050_0093;
    localparam logic [31:0] I2 = 32'h0000_02B7;
    localparam logic [31:0] I3 = 32'h0000_0063;
    localparam logic [31:0] I4 = 32'h00C0_006F;

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; reset2 = 1'b1; auto_mem = 1'b0; pend2 = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; rvalid_tb = 1'b0; rdata_tb = 32'h0;
        instr_ready = 1'b0;

        // Cycle-by-cycle vectors; each row's outputs are sampled before the closing edge.
        vq.push_back(v(0, 0,     0, 0,            1, 1, 32'h0,   0, N,  0,     0));
        vq.push_back(v(0, 0,     1, I1,           1, 0, 0,       0, N,  0,     0));
        vq.push_back(v(0, 0,     0, 0,            1, 0, 0,       1, I1, 0,     0));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h4,   0, I1, 0,     1));
        vq.push_back(v(0, 0,     1, I2,           0, 0, 0,       0, I1, 0,     1));
        vq.push_back(v(0, 0,     1, 32'hDEADBEEF, 0, 0, 0,       1, I2, 32'h4, 1));
        for (int k = 0; k < 4; k++)
            vq.push_back(v(0, 0, 0, 0,            0, 0, 0,       1, I2, 32'h4, 1));
        vq.push_back(v(0, 0,     0, 0,            1, 0, 0,       1, I2, 32'h4, 1));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h8,   0, I2, 32'h4, 2));
        vq.push_back(v(1, 32'h103, 0, 0,          0, 0, 0,       0, I2, 32'h4, 2));
        vq.push_back(v(0, 0,     0, 0,            0, 0, 0,       0, I2, 32'h4, 2));
        vq.push_back(v(0, 0,     1, 32'h12345678, 0, 0, 0,       0, I2, 32'h4, 2));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h100, 0, I2, 32'h4, 2));
        vq.push_back(v(1, 32'h200, 1, 32'hCAFEF00D, 0, 0, 0,     0, I2, 32'h4, 2));
        vq.push_back(v(0, 0,     0, 0,            1, 1, 32'h200, 0, I2, 32'h4, 2));
        vq.push_back(v(0, 0,     1, I3,           0, 0, 0,       0, I2, 32'h4, 2));
        vq.push_back(v(1, 32'h300, 0, 0,          1, 0, 0,       1, I3, 32'h200, 2));
        vq.push_back(v(1, 32'h400, 0, 0,          0, 0, 0,       0, I3, 32'h200, 2));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h400, 0, I3, 32'h200, 2));
        vq.push_back(v(1, 32'h500, 0, 0,          0, 0, 0,       0, I3, 32'h200, 2));
        vq.push_back(v(1, 32'h600, 0, 0,          0, 0, 0,       0, I3, 32'h200, 2));
        vq.push_back(v(0, 0,     1, 32'hAAAA5555, 0, 0, 0,       0, I3, 32'h200, 2));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h600, 0, I3, 32'h200, 2));
        vq.push_back(v(0, 0,     1, I4,           0, 0, 0,       0, I3, 32'h200, 2));
        vq.push_back(v(0, 0,     0, 0,            1, 0, 0,       1, I4, 32'h600, 2));
        vq.push_back(v(0, 0,     0, 0,            0, 1, 32'h604, 0, I4, 32'h600, 3));

        #3;
        chk_out("reset", 1'b0, 32'h0, 1'b0, N, 32'h0, 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        foreach (vq[i]) begin
            redirect    = vq[i].redir;
            redirect_pc = vq[i].rpc;
            rvalid_tb   = vq[i].rvalid;
            rdata_tb    = vq[i].rdata;
            instr_ready = vq[i].ready;
            #3;
            chk_out($sformatf("vec%0d", i), vq[i].exp_req, vq[i].exp_addr, vq[i].exp_valid,
                    vq[i].exp_instr, vq[i].exp_ipc, vq[i].exp_cnt);
            step();
        end
        redirect = 1'b0; rvalid_tb = 1'b0; instr_ready = 1'b0;

        // Async reset in the middle of a WAIT cycle, then a stale beat after release.
        #2;
        RESET = 1'b1;
        #1;
        chk_out("async_reset", 1'b0, 32'h0, 1'b0, N, 32'h0, 32'h0);
        step();
        rvalid_tb = 1'b1; rdata_tb = 32'h0000_0BAD;
        step();
        RESET = 1'b0;
        #3;
        chk_out("restart_req", 1'b1, 32'h0, 1'b0, N, 32'h0, 32'h0);
        step();
        rvalid_tb = 1'b1; rdata_tb = 32'h0010_0093;
        #3;
        chk_out("restart_wait", 1'b0, 32'h0, 1'b0, N, 32'h0, 32'h0);
        step();
        rvalid_tb = 1'b0;

        // FETCH_COUNT wrap: preset just below wrap, then two handshakes.
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        #2;
        chk_out("preset_hold", 1'b0, 32'h0, 1'b1, 32'h0010_0093, 32'h0, 32'hFFFF_FFFE);
        step();
        instr_ready = 1'b1;
        #3;
        chk_out("preset_hs", 1'b0, 32'h0, 1'b1, 32'h0010_0093, 32'h0, 32'hFFFF_FFFE);
        step();
        auto_mem = 1'b1;
        #3;
        chk_out("cnt_max", 1'b1, 32'h4, 1'b0, 32'h0010_0093, 32'h0, 32'hFFFF_FFFF);
        step();
        step();
        #3;
        chk_out("auto_hold", 1'b0, 32'h0, 1'b1, N, 32'h4, 32'hFFFF_FFFF);
        step();
        #3;
        chk_out("cnt_wrap", 1'b1, 32'h8, 1'b0, N, 32'h4, 32'h0);
        step();
        auto_mem = 1'b0; instr_ready = 1'b0;

        // PC wrap on the second instance.
        reset2 = 1'b0;
        #3;
        chk("pcwrap first_req", {31'h0, req2}, 32'h1);
        chk("pcwrap first_addr", addr2, 32'hFFFF_FFFC);
        step();
        step();
        #3;
        chk("pcwrap valid", {31'h0, valid2}, 32'h1);
        chk("pcwrap instr_pc", ipc2, 32'hFFFF_FFFC);
        step();
        #3;
        chk("pcwrap second_req", {31'h0, req2}, 32'h1);
        chk("pcwrap second_addr", addr2, 32'h0);
        chk("pcwrap count", cnt2, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
